// File: rtl/bcx_result_pkg.sv
// ----------------------------------------------------------------------------
// bcx_result_pkg
// Shared types and constants for the nonce result reporter.
//   SYNC_BYTE      first byte of every record, lets the host re-align
//   RECORD_BYTES   bytes per serialized record (sync, tag, 4 nonce bytes)
//   nonce_record_t one buffered result: block tag plus golden nonce
//   reporter_state_t serializer FSM states
//   record_byte()  selects byte idx of a record in wire order
// ----------------------------------------------------------------------------
package bcx_result_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         RECORD_BYTES = 6;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] nonce;
    } nonce_record_t;

    typedef enum logic {
        IDLE,
        SEND
    } reporter_state_t;

    // Wire order: sync, tag, then the nonce most-significant byte first.
    function automatic logic [7:0] record_byte(input nonce_record_t rec,
                                               input logic [2:0]    idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = rec.tag;
            3'd2:    b = rec.nonce[31:24];
            3'd3:    b = rec.nonce[23:16];
            3'd4:    b = rec.nonce[15:8];
            3'd5:    b = rec.nonce[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nonce_result_reporter_if.sv
// ----------------------------------------------------------------------------
// nonce_result_reporter_if
// Valid/ready byte stream from the reporter to the host link.
//   byte_o        record byte (driven by the reporter)
//   byte_valid_o  byte_o is valid (driven by the reporter)
//   byte_ready_i  sink accepts the byte (driven by the host link)
// master = reporter side, slave = host link side.
// ----------------------------------------------------------------------------
interface nonce_result_reporter_if;

    logic [7:0] byte_o;
    logic       byte_valid_o;
    logic       byte_ready_i;

    modport master (
        output byte_o,
        output byte_valid_o,
        input  byte_ready_i
    );

    modport slave (
        input  byte_o,
        input  byte_valid_o,
        output byte_ready_i
    );

endinterface

// File: rtl/result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO for tagged nonce records.
//   clk, rst       clock, asynchronous active-low reset
//   push_i/push_data_i  write request and data
//   pop_i/pop_data_o    read request; pop_data_o shows the head entry
//   full_o, empty_o     status
//   count_o             registered number of held entries
// A push on a full FIFO succeeds only when a pop happens in the same cycle;
// otherwise it is ignored and the caller is expected to flag the drop.
// DEPTH must be a power of 2 and >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module result_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [39:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  T                       push_data_i,
    input  logic                   pop_i,
    output T                       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign pop_ok     = pop_i && !empty_o;
    // The slot freed by a same-cycle pop makes room for the push.
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count decide
    // which entries are meaningful, so resetting it would only cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/nonce_result_reporter.sv
// ----------------------------------------------------------------------------
// nonce_result_reporter
// Captures golden nonces from the decoder, tags each with the current block
// ID, buffers them and serializes every record as 6 bytes on a valid/ready
// byte stream toward the host link.
//   clk, rst      clock, asynchronous active-low reset
//   newblock_i    new-block pulse; advances the block tag
//   valid_i       decoder result valid
//   success_i     decoder result is a golden nonce
//   nonce_i       decoder nonce
//   bs            byte stream (byte_o, byte_valid_o, byte_ready_i)
//   pending_o     records waiting in the FIFO (record in flight excluded)
//   overflow_o    sticky drop flag, cleared by newblock_i
// Record: A5, tag, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
// ----------------------------------------------------------------------------
module nonce_result_reporter
    import bcx_result_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        newblock_i,
    input  logic                        valid_i,
    input  logic                        success_i,
    input  logic [31:0]                 nonce_i,
    nonce_result_reporter_if.master     bs,
    output logic [$clog2(FIFO_DEPTH):0] pending_o,
    output logic                        overflow_o
);

    // Block tag and sticky overflow flag
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             overflow_q, overflow_d;

    // Serializer
    reporter_state_t  state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    nonce_record_t    rec_q, rec_d;

    // FIFO hookup
    nonce_record_t              push_rec;
    nonce_record_t              head_rec;
    logic                       capture;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                       drop;
    logic                       handshake;
    logic                       last_byte;

    assign capture = valid_i && success_i;
    // tag_q is the pre-increment value, so a capture on a newblock edge
    // still belongs to the block that just ended.
    assign push_rec = '{tag: tag_q, nonce: nonce_i};
    assign drop     = capture && fifo_full && !fifo_pop;

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (nonce_record_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (capture),
        .push_data_i (push_rec),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Tag wraps mod 2^TAG_W; a drop on the clearing edge wins over the clear.
    always_comb begin
        tag_d      = newblock_i ? tag_q + TAG_W'(1) : tag_q;
        overflow_d = overflow_q;
        if (drop)            overflow_d = 1'b1;
        else if (newblock_i) overflow_d = 1'b0;
    end

    assign handshake = (state_q == SEND) && bs.byte_ready_i;
    assign last_byte = (idx_q == 3'(RECORD_BYTES - 1));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rec_d    = rec_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    rec_d    = head_rec;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (last_byte) begin
                        idx_d = '0;
                        // Reload straight from the FIFO so records stream
                        // without an idle cycle between them.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            rec_d    = head_rec;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q      <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            idx_q      <= '0;
            rec_q      <= '0;
        end else begin
            tag_q      <= tag_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            rec_q      <= rec_d;
        end
    end

    // Outputs decode registered state only, so byte_ready_i never reaches
    // byte_valid_o combinationally and reset clears them immediately.
    assign bs.byte_valid_o = (state_q == SEND);
    assign bs.byte_o       = (state_q == SEND) ? record_byte(rec_q, idx_q) : 8'h00;
    assign pending_o       = fifo_count;
    assign overflow_o      = overflow_q;

endmodule
